// File: rtl/os_tx_scheduler_pkg.sv
// rtl/os_tx_scheduler_pkg.sv - shared encodings and defaults for the transmit ordered-set scheduler
package os_pkg;

    // Ordered-set type codes understood by the encoder
    localparam logic [2:0] OS_TS1   = 3'd0;
    localparam logic [2:0] OS_TS2   = 3'd1;
    localparam logic [2:0] OS_EIOS  = 3'd2;
    localparam logic [2:0] OS_EIEOS = 3'd3;
    localparam logic [2:0] OS_SKP   = 3'd4;

    // Lane mux select
    typedef enum logic [1:0] {
        SEL_IDLE = 2'd0,
        SEL_OS   = 2'd1,
        SEL_SKP  = 2'd2,
        SEL_DATA = 2'd3
    } tx_sel_t;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OS   = 2'd1,
        ST_SKP  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    // Default SKP insertion intervals in clock cycles
    localparam int SKP_INTERVAL_G12_DEF = 1180;
    localparam int SKP_INTERVAL_G3_DEF  = 370;

endpackage

// File: rtl/os_tx_scheduler_if.sv
// rtl/os_tx_scheduler_if.sv - request, grant and encoder handshake bundle for the scheduler
interface os_tx_scheduler_if;
    logic [2:0] gen;
    logic       link_up;
    logic       skp_en;
    logic       ltssm_os_req;
    logic [2:0] ltssm_os_type;
    logic [7:0] ltssm_os_count;
    logic       ltssm_os_done;
    logic       tlp_req;
    logic       tlp_valid;
    logic       tlp_last;
    logic       tlp_grant;
    logic       os_start;
    logic [2:0] os_type;
    logic       os_sent;
    logic [1:0] tx_sel;
    logic       skp_overrun;

    // Scheduler side
    modport master (
        input  gen, link_up, skp_en,
        input  ltssm_os_req, ltssm_os_type, ltssm_os_count,
        input  tlp_req, tlp_valid, tlp_last, os_sent,
        output ltssm_os_done, tlp_grant, os_start, os_type, tx_sel, skp_overrun
    );

    // Requester / encoder side
    modport slave (
        output gen, link_up, skp_en,
        output ltssm_os_req, ltssm_os_type, ltssm_os_count,
        output tlp_req, tlp_valid, tlp_last, os_sent,
        input  ltssm_os_done, tlp_grant, os_start, os_type, tx_sel, skp_overrun
    );
endinterface

// File: rtl/os_tx_scheduler_skp_timer.sv
// rtl/os_tx_scheduler_skp_timer.sv - SKP interval counter with single pending request and overrun flag
module skp_timer
    import os_pkg::*;
#(
    parameter int SKP_INTERVAL_G12 = SKP_INTERVAL_G12_DEF,
    parameter int SKP_INTERVAL_G3  = SKP_INTERVAL_G3_DEF,
    parameter int CNT_W            = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] gen,
    input  logic       clr,
    output logic       pending,
    output logic       overrun
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic             expire;

    // Compare with >= so a gen change that leaves the count past the new limit wraps immediately
    assign limit  = (gen >= 3'd3) ? CNT_W'(SKP_INTERVAL_G3 - 1) : CNT_W'(SKP_INTERVAL_G12 - 1);
    assign expire = en && (cnt >= limit);

    // Interval counter: held at zero while disabled, wraps on expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending SKP request; a fresh expiry wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if (expire) begin
            pending <= 1'b1;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end

    // Sticky overrun: an expiry landed while an unserviced SKP was still pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (expire && pending && !clr) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/os_tx_scheduler.sv
// rtl/os_tx_scheduler.sv - arbitrates lane transmit between LTSSM bursts, SKP insertion and data
module os_tx_scheduler
    import os_pkg::*;
#(
    parameter int SKP_INTERVAL_G12 = SKP_INTERVAL_G12_DEF,
    parameter int SKP_INTERVAL_G3  = SKP_INTERVAL_G3_DEF,
    parameter int CNT_W            = 11
) (
    input  logic              clk,
    input  logic              reset,
    os_tx_scheduler_if.master bus
);

    state_t     state;
    tx_sel_t    tx_sel;
    logic       ret_os;
    logic [7:0] remaining;
    logic [2:0] os_type;
    logic [2:0] ltssm_type;
    logic       os_start;
    logic       os_done;
    logic       tlp_grant;
    logic       skp_pending;
    logic       skp_overrun;
    logic       skp_clr;
    logic       sent_ok;
    logic       more_due;

    // A completion pulse coinciding with our own start pulse belongs to an older set
    assign sent_ok  = bus.os_sent && !os_start;
    // remaining == 0 only ever holds in continuous mode; count mode finishes on the last set
    assign more_due = (remaining == 8'd0) ? bus.ltssm_os_req : (remaining != 8'd1);
    // Clear combinationally so pending is gone by the time IDLE re-arbitrates
    assign skp_clr  = (state == ST_SKP) && sent_ok;

    skp_timer #(
        .SKP_INTERVAL_G12 (SKP_INTERVAL_G12),
        .SKP_INTERVAL_G3  (SKP_INTERVAL_G3),
        .CNT_W            (CNT_W)
    ) u_skp_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.skp_en),
        .gen     (bus.gen),
        .clr     (skp_clr),
        .pending (skp_pending),
        .overrun (skp_overrun)
    );

    // Scheduler FSM with registered outputs; sets and packets are never preempted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tx_sel     <= SEL_IDLE;
            ret_os     <= 1'b0;
            remaining  <= 8'd0;
            os_type    <= 3'd0;
            ltssm_type <= 3'd0;
            os_start   <= 1'b0;
            os_done    <= 1'b0;
            tlp_grant  <= 1'b0;
        end else begin
            os_start <= 1'b0;
            os_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (skp_pending) begin
                        state    <= ST_SKP;
                        tx_sel   <= SEL_SKP;
                        os_type  <= OS_SKP;
                        os_start <= 1'b1;
                        ret_os   <= 1'b0;
                    end else if (bus.ltssm_os_req) begin
                        state      <= ST_OS;
                        tx_sel     <= SEL_OS;
                        os_type    <= bus.ltssm_os_type;
                        ltssm_type <= bus.ltssm_os_type;
                        remaining  <= bus.ltssm_os_count;
                        os_start   <= 1'b1;
                    end else if (bus.tlp_req && bus.link_up) begin
                        state     <= ST_DATA;
                        tx_sel    <= SEL_DATA;
                        tlp_grant <= 1'b1;
                    end else begin
                        tx_sel <= SEL_IDLE;
                    end
                end
                ST_OS: begin
                    if (sent_ok) begin
                        if (remaining != 8'd0) begin
                            remaining <= remaining - 8'd1;
                        end
                        if (!more_due) begin
                            state   <= ST_IDLE;
                            tx_sel  <= SEL_IDLE;
                            os_done <= 1'b1;
                        end else if (skp_pending) begin
                            state    <= ST_SKP;
                            tx_sel   <= SEL_SKP;
                            os_type  <= OS_SKP;
                            os_start <= 1'b1;
                            ret_os   <= 1'b1;
                        end else begin
                            os_start <= 1'b1;
                        end
                    end
                end
                ST_SKP: begin
                    if (sent_ok) begin
                        ret_os <= 1'b0;
                        if (ret_os) begin
                            state    <= ST_OS;
                            tx_sel   <= SEL_OS;
                            os_type  <= ltssm_type;
                            os_start <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            tx_sel <= SEL_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (!bus.link_up || (bus.tlp_valid && bus.tlp_last)) begin
                        state     <= ST_IDLE;
                        tx_sel    <= SEL_IDLE;
                        tlp_grant <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_sel <= SEL_IDLE;
                end
            endcase
        end
    end

    assign bus.os_start      = os_start;
    assign bus.os_type       = os_type;
    assign bus.ltssm_os_done = os_done;
    assign bus.tlp_grant     = tlp_grant;
    assign bus.tx_sel        = tx_sel;
    assign bus.skp_overrun   = skp_overrun;

endmodule

// File: doc/os_tx_scheduler.md
# os_tx_scheduler

Transmit-side scheduler that shares the lane transmit path between three requesters: the LTSSM (TS1/TS2/EIOS/EIEOS bursts), a periodic SKP ordered-set insertion timer, and the TLP/DLLP data stream. It sits between the LTSSM/link layer and the ordered-set encoder/lane mux, mirroring the receive-side ordered-set decoder. The block never preempts a set or packet in flight, and it inserts SKP sets at the next legal boundary.

## Interface
- SKP_INTERVAL_G12, default 1180: cycles between SKP requests when gen is 1 or 2.
- SKP_INTERVAL_G3, default 370: cycles between SKP requests when gen is 3 or higher.
- CNT_W, default 11: width of the SKP interval counter.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- gen  in  3  current generation (1..5); selects the SKP interval.
- link_up  in  1  data-link up; the DATA grant is only allowed while high.
- skp_en  in  1  SKP timer enable; counter holds at 0 while low.
- ltssm_os_req  in  1  LTSSM requests an ordered-set burst (level).
- ltssm_os_type  in  3  set type; sampled on acceptance.
- ltssm_os_count  in  8  number of sets; 0 = continuous while ltssm_os_req is high.
- ltssm_os_done  out  1  one-cycle pulse when the burst completes.
- tlp_req  in  1  data path has a packet pending.
- tlp_valid  in  1  data beat valid while granted.
- tlp_last  in  1  final beat of the packet.
- tlp_grant  out  1  data path owns the lanes.
- os_start  out  1  one-cycle pulse telling the encoder to emit one set of type os_type.
- os_type  out  3  set type for the encoder.
- os_sent  in  1  encoder pulse: the current set has been fully transmitted.
- tx_sel  out  2  lane mux select: 0 idle, 1 LTSSM OS, 2 SKP, 3 data.
- skp_overrun  out  1  sticky flag: an interval expired while SKP was already pending; cleared by reset.

## Operation
- States are IDLE, OS, SKP and DATA. A return-state register, ret_os, records whether the block returns to OS after a SKP set.
- Arbitration in IDLE uses fixed priority:
  - skp_pending goes to SKP.
  - Otherwise ltssm_os_req goes to OS. On this transition the block latches ltssm_os_type into os_type and ltssm_os_count into remaining.
  - Otherwise tlp_req && link_up goes to DATA.
- OS state:
  - os_start pulses on entry and again after each os_sent while sets remain.
  - On os_sent with count mode, remaining is decremented. Reaching 0 pulses ltssm_os_done and returns to IDLE.
  - On os_sent with continuous mode (count 0) and ltssm_os_req low: pulse ltssm_os_done and go to IDLE.
  - On os_sent with more sets due and skp_pending set: set ret_os and go to SKP. After the SKP set completes, resume OS with the next set. remaining is unchanged by the SKP set.
- SKP state: os_type is 4 (SKP) and os_start pulses on entry. On os_sent, clear skp_pending and go to OS if ret_os is set, otherwise to IDLE; ret_os is cleared.
- DATA state:
  - tlp_grant is high.
  - On tlp_valid && tlp_last, go to IDLE. skp_pending is then serviced ahead of the next packet.
  - If link_up falls, drop tlp_grant and go to IDLE next cycle, even mid-packet.
- SKP timer:
  - Counts while skp_en is high. When it reaches the selected interval minus 1, it wraps to 0 and sets skp_pending.
  - If skp_pending is already set at expiry, set skp_overrun. Only one SKP is pending at a time.
  - A gen change does not reset the counter. If the counter is already at or beyond the new interval, it wraps at the next compare.
- os_sent is ignored in IDLE and DATA, and in the cycle os_start is high.

## Timing
- Reset values: state IDLE; all outputs 0; tx_sel 0; os_type 0; counter, remaining, skp_pending and ret_os all 0.
- All outputs are registered. A request sampled high in IDLE at cycle N gives a new state, tx_sel and os_start/tlp_grant at cycle N+1.
- os_sent at cycle M gives the next os_start at M+1, or the state change at M+1.
- ltssm_os_done is high for exactly the cycle after the final os_sent.
- A SKP expiry and an IDLE-state request in the same cycle: skp_pending becomes visible at N+1, so the other request wins at N+1. SKP is serviced at the following boundary.
- Reset assertion mid-operation clears everything immediately. No done pulse is generated.

## Structure
- Package os_pkg holds:
  - set-type encodings: TS1=0, TS2=1, EIOS=2, EIEOS=3, SKP=4;
  - tx_sel encodings;
  - state enum;
  - default SKP intervals.
- One natural sub-module: skp_timer. It holds the interval counter, skp_pending and skp_overrun, with a clear input from the scheduler.

## Test plan
- ltssm_os_req with type TS1 and count 3; os_sent returned 4 cycles after each os_start -> exactly 3 os_start pulses, tx_sel=1 throughout, then one ltssm_os_done pulse, then IDLE.
- gen=1, skp_en=1, no other traffic -> os_start with os_type=4 and tx_sel=2 every 1180 cycles (plus the os_sent latency). With gen=3 the period is 370.
- DATA packet of 20 beats with SKP expiring at beat 5 -> tlp_grant is held until tlp_last. SKP os_start occurs 1 cycle after the IDLE cycle that follows tlp_last.
- TS2 with count 8 and SKP expiring after set 2 -> sequence TS2×2, SKP, TS2×6, then done. Total os_start pulses = 9.
- SKP blocked by a long packet (3000 cycles, gen=1) -> skp_overrun=1 and only one SKP is issued afterwards.
- link_up dropped mid-packet -> tlp_grant is 0 next cycle and tx_sel is 0. Reset asserted mid-OS burst -> all outputs 0 asynchronously, with no ltssm_os_done.
